ifu_pcgen: RTL and testbench

//  Instruction-fetch PC generator for the NPC front end. Holds the architectural fetch PC and

---
 rtl/ifu_pcgen.sv | 76 +++++++
 tb/tb_ifu_pcgen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ifu_pcgen.sv
// ifu_pcgen: fetch PC generator, one imem request in flight, single-entry decode buffer, redirect handling
module ifu_pcgen #(
   parameter int            AW       = 64,
   parameter int            IW       = 32,
   parameter logic [AW-1:0] RESET_PC = 64'h8000_0000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          redirect_vld,
   input  logic [AW-1:0] redirect_pc,
   output logic          imem_req_vld,
   input  logic          imem_req_rdy,
   output logic [AW-1:0] imem_req_addr,
   input  logic          imem_rsp_vld,
   input  logic [IW-1:0] imem_rsp_data,
   output logic          dec_inst_vld,
   input  logic          dec_inst_rdy,
   output logic [IW-1:0] dec_inst,
   output logic [AW-1:0] dec_pc
);
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
   state_t        r_state;
   logic [AW-1:0] r_pc, r_dpc;
   logic [IW-1:0] r_inst;
   logic          r_drop;
   logic [AW-1:0] w_tgt;
   assign w_tgt         = redirect_pc & ~AW'(3);
   assign imem_req_vld  = r_state == S_REQ;
   assign imem_req_addr = r_pc;
   assign dec_inst_vld  = (r_state == S_HOLD) & ~redirect_vld;
   assign dec_inst      = r_inst;
   assign dec_pc        = r_dpc;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_REQ;
         r_pc    <= RESET_PC & ~AW'(3);
         r_drop  <= 1'b0;
         r_inst  <= '0;
         r_dpc   <= '0;
      end else if (redirect_vld) begin
         r_pc <= w_tgt;
         // an accepted or still-outstanding fetch is now wrong-path and must be discarded
         case (r_state)
            S_REQ: if (imem_req_rdy) begin
               r_state <= S_WAIT;
               r_drop  <= 1'b1;
            end
            S_WAIT: begin
               r_state <= imem_rsp_vld ? S_REQ : S_WAIT;
               r_drop  <= ~imem_rsp_vld;
            end
            default: r_state <= S_REQ;
         endcase
      end else begin
         case (r_state)
            S_REQ: if (imem_req_rdy) r_state <= S_WAIT;
            S_WAIT: if (imem_rsp_vld) begin
               r_drop  <= 1'b0;
               r_state <= r_drop ? S_REQ : S_HOLD;
               if (!r_drop) begin
                  r_inst <= imem_rsp_data;
                  r_dpc  <= r_pc;
                  r_pc   <= r_pc + AW'(4);
               end
            end
            default: if (dec_inst_rdy) r_state <= S_REQ;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (r_state inside {S_REQ, S_WAIT, S_HOLD});
         assert (!(r_drop && r_state != S_WAIT));
      end
   end
endmodule

// File: tb/tb_ifu_pcgen.sv
// tb_ifu_pcgen: directed vector table, parameter/reset corner sequence, randomized run against a transaction-level model
module tb_ifu_pcgen;
   logic        clk = 1'b0;
   logic        rst, redirect_vld, imem_req_rdy, imem_rsp_vld, dec_inst_rdy;
   logic [63:0] redirect_pc;
   logic [31:0] imem_rsp_data;
   logic        imem_req_vld, dec_inst_vld, imem_req_vld2, dec_inst_vld2;
   logic [63:0] imem_req_addr, dec_pc, imem_req_addr2, dec_pc2;
   logic [31:0] dec_inst, dec_inst2;
   int          n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   ifu_pcgen dut (
      .clk(clk), .rst(rst), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
      .imem_req_vld(imem_req_vld), .imem_req_rdy(imem_req_rdy), .imem_req_addr(imem_req_addr),
      .imem_rsp_vld(imem_rsp_vld), .imem_rsp_data(imem_rsp_data),
      .dec_inst_vld(dec_inst_vld), .dec_inst_rdy(dec_inst_rdy), .dec_inst(dec_inst), .dec_pc(dec_pc));

   ifu_pcgen #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
      .clk(clk), .rst(rst), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
      .imem_req_vld(imem_req_vld2), .imem_req_rdy(imem_req_rdy), .imem_req_addr(imem_req_addr2),
      .imem_rsp_vld(imem_rsp_vld), .imem_rsp_data(imem_rsp_data),
      .dec_inst_vld(dec_inst_vld2), .dec_inst_rdy(dec_inst_rdy), .dec_inst(dec_inst2), .dec_pc(dec_pc2));

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   typedef struct {
      bit rv; logic [63:0] rpc; bit rdy, rsp; logic [31:0] data; bit drdy;
      bit e_req; logic [63:0] e_addr; bit e_dec; logic [31:0] e_inst; logic [63:0] e_pc;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t v(bit rv, logic [63:0] rpc, bit rdy, bit rsp, logic [31:0] data, bit drdy,
                              bit e_req, logic [63:0] e_addr, bit e_dec, logic [31:0] e_inst, logic [63:0] e_pc);
      vec_t r;
      r.rv = rv; r.rpc = rpc; r.rdy = rdy; r.rsp = rsp; r.data = data; r.drdy = drdy;
      r.e_req = e_req; r.e_addr = e_addr; r.e_dec = e_dec; r.e_inst = e_inst; r.e_pc = e_pc;
      return r;
   endfunction

   task automatic drive(bit r, bit rv, logic [63:0] rpc, bit rdy, bit rsp, logic [31:0] data, bit drdy);
      rst = r; redirect_vld = rv; redirect_pc = rpc; imem_req_rdy = rdy;
      imem_rsp_vld = rsp; imem_rsp_data = data; dec_inst_rdy = drdy;
   endtask

   // Reference model: an outstanding-fetch flag, a wrong-path flag and a decode queue of depth <= 1
   typedef struct {logic [31:0] inst; logic [63:0] pc;} ent_t;
   ent_t        m_q[$];
   bit          m_inflight, m_wrong;
   logic [63:0] m_pc, m_last_pc;
   logic [31:0] m_last_inst;

   task automatic model_step();
      bit fire, got;
      if (rst) begin
         m_pc = 64'h8000_0000; m_inflight = 0; m_wrong = 0; m_q.delete();
         m_last_pc = 0; m_last_inst = 0;
         return;
      end
      fire = !m_inflight && m_q.size() == 0 && imem_req_rdy;
      got  = m_inflight && imem_rsp_vld;
      if (redirect_vld) begin
         m_pc = {redirect_pc[63:2], 2'b00};
         m_q.delete();
         if (fire) begin m_inflight = 1; m_wrong = 1; end
         else if (got) begin m_inflight = 0; m_wrong = 0; end
         else if (m_inflight) m_wrong = 1;
      end else begin
         if (m_q.size() != 0 && dec_inst_rdy) void'(m_q.pop_front());
         if (fire) m_inflight = 1;
         if (got) begin
            m_inflight = 0;
            if (m_wrong) m_wrong = 0;
            else begin
               m_q.push_back('{imem_rsp_data, m_pc});
               m_last_inst = imem_rsp_data; m_last_pc = m_pc;
               m_pc = m_pc + 64'd4;
            end
         end
      end
   endtask

   task automatic model_check();
      cmp("rnd_req_vld", {63'd0, imem_req_vld}, {63'd0, !m_inflight && m_q.size() == 0});
      cmp("rnd_req_addr", imem_req_addr, m_pc);
      cmp("rnd_dec_vld", {63'd0, dec_inst_vld}, {63'd0, m_q.size() != 0 && !redirect_vld});
      cmp("rnd_dec_inst", {32'd0, dec_inst}, {32'd0, m_last_inst});
      cmp("rnd_dec_pc", dec_pc, m_last_pc);
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cmp("rst_req_vld", {63'd0, imem_req_vld}, 64'd1);
      cmp("rst_req_addr", imem_req_addr, 64'h8000_0000);
      cmp("rst_dec_vld", {63'd0, dec_inst_vld}, 64'd0);
      cmp("rst_dec_inst", {32'd0, dec_inst}, 64'd0);
      @(posedge clk); #1;

      // columns: rv rpc rdy rsp data drdy | req addr dec inst pc
      tbl.push_back(v(0, 0, 1, 0, 0, 0,                      1, 64'h8000_0000, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 32'h13, 0,                 0, 64'h8000_0000, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 1,                      0, 64'h8000_0004, 1, 32'h13, 64'h8000_0000));
      tbl.push_back(v(0, 0, 0, 0, 0, 0,                      1, 64'h8000_0004, 0, 32'h13, 64'h8000_0000));
      tbl.push_back(v(0, 0, 1, 0, 0, 0,                      1, 64'h8000_0004, 0, 32'h13, 64'h8000_0000));
      tbl.push_back(v(0, 0, 0, 1, 32'h0010_0093, 0,          0, 64'h8000_0004, 0, 32'h13, 64'h8000_0000));
      for (int i = 0; i < 5; i++)
         tbl.push_back(v(0, 0, 0, 0, 0, 0,                   0, 64'h8000_0008, 1, 32'h0010_0093, 64'h8000_0004));
      tbl.push_back(v(0, 0, 0, 0, 0, 1,                      0, 64'h8000_0008, 1, 32'h0010_0093, 64'h8000_0004));
      tbl.push_back(v(0, 0, 1, 0, 0, 0,                      1, 64'h8000_0008, 0, 32'h0010_0093, 64'h8000_0004));
      tbl.push_back(v(1, 64'h8000_1001, 0, 0, 0, 0,          0, 64'h8000_0008, 0, 32'h0010_0093, 64'h8000_0004));
      tbl.push_back(v(0, 0, 0, 0, 0, 0,                      0, 64'h8000_1000, 0, 32'h0010_0093, 64'h8000_0004));
      tbl.push_back(v(0, 0, 0, 1, 32'hDEAD_BEEF, 0,          0, 64'h8000_1000, 0, 32'h0010_0093, 64'h8000_0004));
      tbl.push_back(v(0, 0, 0, 0, 0, 0,                      1, 64'h8000_1000, 0, 32'h0010_0093, 64'h8000_0004));
      tbl.push_back(v(0, 0, 1, 0, 0, 0,                      1, 64'h8000_1000, 0, 32'h0010_0093, 64'h8000_0004));
      tbl.push_back(v(1, 64'h8000_2000, 0, 1, 32'h0BAD_0BAD, 0, 0, 64'h8000_1000, 0, 32'h0010_0093, 64'h8000_0004));
      tbl.push_back(v(0, 0, 1, 0, 0, 0,                      1, 64'h8000_2000, 0, 32'h0010_0093, 64'h8000_0004));
      tbl.push_back(v(0, 0, 0, 1, 32'h73, 0,                 0, 64'h8000_2000, 0, 32'h0010_0093, 64'h8000_0004));
      tbl.push_back(v(1, 64'h8000_3000, 0, 0, 0, 1,          0, 64'h8000_2004, 0, 32'h73, 64'h8000_2000));
      tbl.push_back(v(1, 64'h8000_4000, 1, 0, 0, 0,          1, 64'h8000_3000, 0, 32'h73, 64'h8000_2000));
      tbl.push_back(v(1, 64'h8000_5002, 0, 0, 0, 0,          0, 64'h8000_4000, 0, 32'h73, 64'h8000_2000));
      tbl.push_back(v(0, 0, 0, 1, 32'h1, 0,                  0, 64'h8000_5000, 0, 32'h73, 64'h8000_2000));
      tbl.push_back(v(0, 0, 1, 0, 0, 0,                      1, 64'h8000_5000, 0, 32'h73, 64'h8000_2000));
      tbl.push_back(v(0, 0, 0, 1, 32'h13, 0,                 0, 64'h8000_5000, 0, 32'h73, 64'h8000_2000));
      tbl.push_back(v(0, 0, 0, 0, 0, 1,                      0, 64'h8000_5004, 1, 32'h13, 64'h8000_5000));
      tbl.push_back(v(0, 0, 0, 1, 32'hFFFF_FFFF, 0,          1, 64'h8000_5004, 0, 32'h13, 64'h8000_5000));
      tbl.push_back(v(0, 0, 0, 0, 0, 0,                      1, 64'h8000_5004, 0, 32'h13, 64'h8000_5000));
      foreach (tbl[i]) begin
         drive(0, tbl[i].rv, tbl[i].rpc, tbl[i].rdy, tbl[i].rsp, tbl[i].data, tbl[i].drdy);
         @(negedge clk);
         cmp($sformatf("vec%0d_req_vld", i), {63'd0, imem_req_vld}, {63'd0, tbl[i].e_req});
         cmp($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
         cmp($sformatf("vec%0d_dec_vld", i), {63'd0, dec_inst_vld}, {63'd0, tbl[i].e_dec});
         cmp($sformatf("vec%0d_dec_inst", i), {32'd0, dec_inst}, {32'd0, tbl[i].e_inst});
         cmp($sformatf("vec%0d_dec_pc", i), dec_pc, tbl[i].e_pc);
         @(posedge clk); #1;
      end

      // wrap-around PC and reset abandoning an outstanding fetch (second instance)
      drive(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1 drive(0, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      cmp("wrap_req_vld0", {63'd0, imem_req_vld2}, 64'd1);
      cmp("wrap_req_addr0", imem_req_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
      @(posedge clk); #1 drive(0, 0, 0, 0, 1, 32'h13, 0);
      @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      cmp("wrap_dec_vld", {63'd0, dec_inst_vld2}, 64'd1);
      cmp("wrap_dec_pc", dec_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
      cmp("wrap_pc", imem_req_addr2, 64'd0);
      @(posedge clk); #1 drive(0, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      cmp("wrap_req_vld1", {63'd0, imem_req_vld2}, 64'd1);
      cmp("wrap_req_addr1", imem_req_addr2, 64'd0);
      @(posedge clk); #1 drive(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1 drive(0, 0, 0, 0, 1, 32'h55, 0);
      @(negedge clk);
      cmp("late_req_vld", {63'd0, imem_req_vld2}, 64'd1);
      cmp("late_req_addr", imem_req_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
      @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cmp("late_req_vld2", {63'd0, imem_req_vld2}, 64'd1);
      cmp("late_dec_vld", {63'd0, dec_inst_vld2}, 64'd0);
      cmp("late_dec_inst", {32'd0, dec_inst2}, 64'd0);
      cmp("late_req_addr2", imem_req_addr2, 64'hFFFF_FFFF_FFFF_FFFC);

      // randomized run against the reference model
      drive(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); model_step(); #1;
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, {$urandom, $urandom},
               1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom, 1'($urandom_range(0, 1)));
         @(negedge clk);
         model_check();
         @(posedge clk); model_step(); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
